// File: rtl/dspb_serum_qsys_nios2_qsys_0_mult_seq.sv
// Two-pass 32x32->32 multiply sequencer feeding a 32x16 mult cell (optional feature: MULT_SEQ_SKIP_HI_EN).
// Latency: result valid CELL_LATENCY+3 cycles after request handshake (CELL_LATENCY+2 when high pass skipped).
// Backpressure: one op in flight; req_ready low while busy, result held until rsp_ready.
module dspb_serum_qsys_nios2_qsys_0_mult_seq #(
    parameter int CELL_LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_src1,
    input  logic [31:0] req_src2,
    output logic [31:0] mul_src1,
    output logic [31:0] mul_src2,
    input  logic [31:0] mul_cell_result,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_result
);

    typedef enum logic [2:0] {IDLE, ISSUE_LO, ISSUE_HI, DRAIN, DONE} state_t;

    localparam logic [3:0] CAP_LO = 4'(1 + CELL_LATENCY);
    localparam logic [3:0] CAP_HI = 4'(2 + CELL_LATENCY);

    state_t      state, state_nxt;
    logic [31:0] s1, s2, p0;
    logic [3:0]  cyc_cnt;
    logic [31:0] mul_src1_nxt, mul_src2_nxt;
    logic        req_hs, rsp_hs, busy, cap_lo, cap_hi, cap_last, skip_hi;

`ifdef MULT_SEQ_SKIP_HI_EN
    assign skip_hi = (s2[31:16] == 16'h0);
`else
    assign skip_hi = 1'b0;
`endif

    assign req_ready = (state == IDLE);
    assign req_hs    = req_valid && req_ready;
    assign rsp_hs    = rsp_valid && rsp_ready;
    assign busy      = (state == ISSUE_LO) || (state == ISSUE_HI) || (state == DRAIN);
    // Products are captured on a cycle count from the handshake, not on state.
    assign cap_lo    = busy && (cyc_cnt == CAP_LO);
    assign cap_hi    = busy && (cyc_cnt == CAP_HI);
    assign cap_last  = skip_hi ? cap_lo : cap_hi;

    always_comb begin
        state_nxt    = state;
        mul_src1_nxt = 32'h0;
        mul_src2_nxt = 32'h0;
        case (state)
            IDLE: begin
                if (req_hs) begin
                    state_nxt    = ISSUE_LO;
                    mul_src1_nxt = req_src1;
                    mul_src2_nxt = {16'h0, req_src2[15:0]};
                end
            end
            ISSUE_LO: begin
                if (skip_hi) begin
                    state_nxt = DRAIN;
                end else begin
                    state_nxt    = ISSUE_HI;
                    mul_src1_nxt = s1;
                    mul_src2_nxt = {16'h0, s2[31:16]};
                end
            end
            ISSUE_HI: state_nxt = DRAIN;
            DRAIN:    if (cap_last) state_nxt = DONE;
            DONE:     if (rsp_hs) state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            s1         <= 32'h0;
            s2         <= 32'h0;
            p0         <= 32'h0;
            cyc_cnt    <= 4'h0;
            mul_src1   <= 32'h0;
            mul_src2   <= 32'h0;
            rsp_valid  <= 1'b0;
            rsp_result <= 32'h0;
        end else begin
            state    <= state_nxt;
            mul_src1 <= mul_src1_nxt;
            mul_src2 <= mul_src2_nxt;
            if (state == IDLE && req_hs) begin
                s1      <= req_src1;
                s2      <= req_src2;
                cyc_cnt <= 4'h1;
            end else if (busy) begin
                cyc_cnt <= cyc_cnt + 4'h1;
            end
            if (cap_lo) begin
                p0 <= mul_cell_result;
            end
            // On a skipped high pass the low product is the whole answer.
            if (cap_last) begin
                rsp_result <= skip_hi ? mul_cell_result
                                      : p0 + {mul_cell_result[15:0], 16'h0};
                rsp_valid  <= 1'b1;
            end else if (rsp_hs) begin
                rsp_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_dspb_serum_qsys_nios2_qsys_0_mult_seq.sv
// Bench for the two-pass multiply sequencer with a behavioural 32x16 cell and reference model.
module tb_dspb_serum_qsys_nios2_qsys_0_mult_seq;

    localparam int L = 1;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_src1 = 32'h0;
    logic [31:0] req_src2 = 32'h0;
    logic [31:0] mul_src1, mul_src2, mul_cell_result;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [31:0] rsp_result;

    int checks = 0;
    int errors = 0;

    dspb_serum_qsys_nios2_qsys_0_mult_seq #(.CELL_LATENCY(L)) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_src1(req_src1), .req_src2(req_src2),
        .mul_src1(mul_src1), .mul_src2(mul_src2),
        .mul_cell_result(mul_cell_result),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result)
    );

    always #5 clk = ~clk;

    // Behavioural 32x16 cell: L-stage pipeline sharing the reset.
    logic [31:0] pipe [L];
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < L; i++) pipe[i] <= 32'h0;
        end else begin
            pipe[0] <= mul_src1 * {16'h0, mul_src2[15:0]};
            for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
        end
    end
    assign mul_cell_result = pipe[L-1];

    function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
        logic [63:0] full;
        full = 64'(a) * 64'(b);
        return full[31:0];
    endfunction

    function automatic int ref_lat(input logic [31:0] b);
`ifdef MULT_SEQ_SKIP_HI_EN
        if (b[31:16] == 16'h0) return 2 + L;
`endif
        return 3 + L;
    endfunction

    // Drives one request and returns the observed result, latency and hold/idle status.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input int hold,
                          output logic [31:0] res, output int lat,
                          output bit held_ok, output bit idle_ok);
        int w;
        held_ok   = 1'b1;
        rsp_ready = (hold == 0);
        req_src1  = a;
        req_src2  = b;
        req_valid = 1'b1;
        w = 0;
        while (!req_ready && w < 32) begin
            @(posedge clk); #1; w++;
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 64) begin
            @(posedge clk); #1; lat++;
        end
        res = rsp_result;
        if (hold > 0) begin
            req_src1  = $urandom;
            req_src2  = $urandom;
            req_valid = 1'b1;
            for (int h = 0; h < hold; h++) begin
                @(posedge clk); #1;
                if (rsp_result !== res || rsp_valid !== 1'b1 || req_ready !== 1'b0 ||
                    mul_src1 !== 32'h0)
                    held_ok = 1'b0;
            end
            rsp_ready = 1'b1;
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        idle_ok = (rsp_valid === 1'b0) && (req_ready === 1'b1) && (mul_src1 === 32'h0);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_result !== 32'h0 ||
            mul_src1 !== 32'h0 || mul_src2 !== 32'h0) begin
            errors++;
            $display("FAIL reset: rdy=%b vld=%b res=%h s1=%h s2=%h, want 1 0 0 0 0",
                     req_ready, rsp_valid, rsp_result, mul_src1, mul_src2);
        end
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        int lat;
        req_src1 = 32'd3; req_src2 = 32'd5; req_valid = 1'b1; rsp_ready = 1'b1;
        checks++;
        if (req_ready !== 1'b1) begin
            errors++; $display("FAIL basic_req_ready: got %b want 1", req_ready);
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        checks++;
        if (mul_src1 !== 32'd3 || mul_src2 !== 32'd5) begin
            errors++; $display("FAIL basic_lo_pass: got %h/%h want 3/5", mul_src1, mul_src2);
        end
        @(posedge clk); #1;
        checks++;
        if (mul_src2 !== 32'd0) begin
            errors++; $display("FAIL basic_hi_pass: got %h want 0", mul_src2);
        end
        lat = 2;
        while (!rsp_valid && lat < 64) begin
            @(posedge clk); #1; lat++;
        end
        checks++;
        if (lat != ref_lat(32'd5) || rsp_result !== 32'h0000000F) begin
            errors++;
            $display("FAIL basic_result: got lat %0d res %h want lat %0d res 0000000f",
                     lat, rsp_result, ref_lat(32'd5));
        end
        @(posedge clk); #1;
        checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || mul_src1 !== 32'h0) begin
            errors++;
            $display("FAIL basic_after_hs: got vld %b rdy %b s1 %h want 0 1 0",
                     rsp_valid, req_ready, mul_src1);
        end
    endtask

    task automatic test_vectors();
        logic [31:0] a_tab [5] = '{32'h0000FFFF, 32'hFFFFFFFF, 32'h00010000, 32'd9, 32'd2};
        logic [31:0] b_tab [5] = '{32'h00020000, 32'hFFFFFFFF, 32'h00010000, 32'h0000000A, 32'h80000001};
        logic [31:0] e_tab [5] = '{32'hFFFE0000, 32'h00000001, 32'h00000000, 32'h0000005A, 32'h00000002};
        logic [31:0] res;
        int lat;
        bit held_ok, idle_ok;
        for (int i = 0; i < 5; i++) begin
            run_op(a_tab[i], b_tab[i], 0, res, lat, held_ok, idle_ok);
            checks++;
            if (res !== e_tab[i] || lat != ref_lat(b_tab[i]) || !idle_ok) begin
                errors++;
                $display("FAIL vector%0d: got res %h lat %0d idle %b want res %h lat %0d idle 1",
                         i, res, lat, idle_ok, e_tab[i], ref_lat(b_tab[i]));
            end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] res;
        int lat;
        bit held_ok, idle_ok;
        run_op(32'd7, 32'h00030005, 5, res, lat, held_ok, idle_ok);
        checks++;
        if (res !== 32'h00150023 || lat != ref_lat(32'h00030005)) begin
            errors++;
            $display("FAIL backpressure_result: got %h lat %0d want 00150023 lat %0d",
                     res, lat, ref_lat(32'h00030005));
        end
        checks++;
        if (!held_ok || !idle_ok) begin
            errors++;
            $display("FAIL backpressure_hold: got held %b idle %b want 1 1", held_ok, idle_ok);
        end
    endtask

    task automatic test_mid_reset();
        logic [31:0] res;
        int lat;
        bit held_ok, idle_ok, saw_vld;
        req_src1 = 32'h12345678; req_src2 = 32'h9ABCDEF0; req_valid = 1'b1; rsp_ready = 1'b0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b0;
        #1;
        checks++;
        if (rsp_valid !== 1'b0 || rsp_result !== 32'h0 || mul_src1 !== 32'h0 ||
            mul_src2 !== 32'h0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL midreset_outputs: got vld %b res %h s1 %h s2 %h rdy %b want 0 0 0 0 1",
                     rsp_valid, rsp_result, mul_src1, mul_src2, req_ready);
        end
        @(negedge clk);
        reset_n = 1'b1;
        saw_vld = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (rsp_valid !== 1'b0 || req_ready !== 1'b1) saw_vld = 1'b1;
        end
        checks++;
        if (saw_vld) begin
            errors++; $display("FAIL midreset_quiet: got activity after abort want none");
        end
        run_op(32'd2, 32'd2, 0, res, lat, held_ok, idle_ok);
        checks++;
        if (res !== 32'd4 || lat != ref_lat(32'd2)) begin
            errors++;
            $display("FAIL midreset_next: got %h lat %0d want 00000004 lat %0d",
                     res, lat, ref_lat(32'd2));
        end
    endtask

    task automatic test_random();
        logic [31:0] a, b, res;
        int lat, hold;
        bit held_ok, idle_ok;
        for (int i = 0; i < 24; i++) begin
            a = $urandom;
            b = $urandom;
            if (i % 3 == 0) b[31:16] = 16'h0;
            hold = $urandom_range(0, 3);
            run_op(a, b, hold, res, lat, held_ok, idle_ok);
            checks++;
            if (res !== ref_mul(a, b) || lat != ref_lat(b) || !held_ok || !idle_ok) begin
                errors++;
                $display("FAIL random%0d: %h*%h got %h lat %0d hold %b idle %b want %h lat %0d 1 1",
                         i, a, b, res, lat, held_ok, idle_ok, ref_mul(a, b), ref_lat(b));
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_vectors();
        test_backpressure();
        test_mid_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
